mux_cfg_frame_loader: RTL and testbench

//   Configuration-memory stage feeding the TGATE routing/LUT mux primitives.

---
 rtl/mux_cfg_frame_loader.sv | 234 +++++++++++++++++++++++
 tb/tb_mux_cfg_frame_loader.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_cfg_frame_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mux_cfg_frame_loader
// Description : Configuration-memory stage for the TGATE routing/LUT muxes.
//               Collects one frame as WORD_W-bit words on a valid/ready port
//               into a shadow register. It then checks that every
//               ONEHOT_GROUP-bit mux select group is one-hot or all-zero.
//               Only after that check does it copy the frame into mem/mem_inv
//               in a single cycle. The muxes therefore never see a partial
//               frame or a select pattern that turns on two TGATEs at once.
// Ports       : prog_clk   - configuration clock, rising edge
//               pReset     - synchronous active-high reset
//               in_valid   - word valid
//               in_ready   - loader can accept a word
//               in_data    - frame word; bit j of word k -> shadow[k*WORD_W+j]
//               in_last    - final word of the frame
//               mem        - committed select bits [0:MEM_SIZE-1]
//               mem_inv    - registered complement of mem
//               load_done  - 1-cycle pulse, frame committed
//               err_len    - 1-cycle pulse, wrong frame length, frame dropped
//               err_onehot - 1-cycle pulse, group check failed, frame dropped
//               cfg_busy   - high whenever the FSM is not IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module mux_cfg_frame_loader #(
    parameter int MEM_SIZE     = 8,
    parameter int WORD_W       = 4,
    parameter int ONEHOT_GROUP = 4
) (
    input  logic                prog_clk,
    input  logic                pReset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WORD_W-1:0]   in_data,
    input  logic                in_last,
    output logic [0:MEM_SIZE-1] mem,
    output logic [0:MEM_SIZE-1] mem_inv,
    output logic                load_done,
    output logic                err_len,
    output logic                err_onehot,
    output logic                cfg_busy
);

    localparam int c_NWORDS  = MEM_SIZE / WORD_W;
    localparam int c_NGROUPS = MEM_SIZE / ONEHOT_GROUP;
    localparam int c_CNT_W   = $clog2(c_NWORDS) + 1;
    localparam int c_POP_W   = $clog2(ONEHOT_GROUP) + 1;

    localparam logic [c_CNT_W-1:0] c_CNT_ZERO = '0;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_NWORDS - 1);
    localparam logic [c_POP_W-1:0] c_POP_ONE  = c_POP_W'(1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_DRAIN  = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_COMMIT = 3'd4;

    logic [2:0]          r_state;
    logic [c_CNT_W-1:0]  r_count;
    logic [0:MEM_SIZE-1] r_shadow;
    logic [0:MEM_SIZE-1] r_mem;
    logic [0:MEM_SIZE-1] r_mem_inv;
    logic                r_load_done;
    logic                r_err_len;
    logic                r_err_onehot;

    logic [2:0]          w_state_nxt;
    logic [c_CNT_W-1:0]  w_count_nxt;
    logic [c_CNT_W-1:0]  w_wr_idx;
    logic                w_accept;
    logic                w_ready_state;
    logic                w_wr_en;
    logic                w_clr;
    logic                w_commit;
    logic                w_err_len_set;
    logic                w_err_onehot_set;
    logic [c_NGROUPS-1:0] w_group_ok;
    logic                w_all_ok;

    // in_ready is gated by pReset so no word appears accepted while the
    // loader is being reset.
    assign w_ready_state = (r_state == S_IDLE) || (r_state == S_LOAD) || (r_state == S_DRAIN);
    assign in_ready      = w_ready_state & ~pReset;
    assign w_accept      = in_valid & in_ready;

    // A group passes when at most one of its select bits is set.
    generate
        for (genvar g = 0; g < c_NGROUPS; g++) begin : g_group
            logic [c_POP_W-1:0] w_pop;
            always_comb begin
                w_pop = '0;
                for (int b = 0; b < ONEHOT_GROUP; b++) begin
                    w_pop = w_pop + c_POP_W'(r_shadow[g*ONEHOT_GROUP + b]);
                end
            end
            assign w_group_ok[g] = (w_pop <= c_POP_ONE);
        end
    endgenerate

    assign w_all_ok = &w_group_ok;

    always_comb begin
        w_state_nxt      = r_state;
        w_count_nxt      = r_count;
        w_wr_idx         = r_count;
        w_wr_en          = 1'b0;
        w_clr            = 1'b0;
        w_commit         = 1'b0;
        w_err_len_set    = 1'b0;
        w_err_onehot_set = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_wr_idx = c_CNT_ZERO;
                if (w_accept) begin
                    if (in_last) begin
                        if (c_NWORDS == 1) begin
                            w_wr_en     = 1'b1;
                            w_count_nxt = c_CNT_ONE;
                            w_state_nxt = S_CHECK;
                        end else begin
                            w_err_len_set = 1'b1;
                            w_clr         = 1'b1;
                        end
                    end else if (c_NWORDS == 1) begin
                        // A one-word frame without in_last is already too long.
                        w_err_len_set = 1'b1;
                        w_clr         = 1'b1;
                        w_state_nxt   = S_DRAIN;
                    end else begin
                        w_wr_en     = 1'b1;
                        w_count_nxt = c_CNT_ONE;
                        w_state_nxt = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (w_accept) begin
                    w_wr_en     = 1'b1;
                    w_count_nxt = r_count + c_CNT_ONE;
                    if (in_last) begin
                        if (r_count == c_CNT_LAST) begin
                            w_state_nxt = S_CHECK;
                        end else begin
                            w_err_len_set = 1'b1;
                            w_clr         = 1'b1;
                            w_count_nxt   = c_CNT_ZERO;
                            w_state_nxt   = S_IDLE;
                        end
                    end else if (r_count == c_CNT_LAST) begin
                        // Frame is full but the sender keeps going: drop it
                        // and swallow words up to its in_last.
                        w_err_len_set = 1'b1;
                        w_clr         = 1'b1;
                        w_count_nxt   = c_CNT_ZERO;
                        w_state_nxt   = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (w_accept && in_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CHECK: begin
                if (w_all_ok) begin
                    w_state_nxt = S_COMMIT;
                end else begin
                    w_err_onehot_set = 1'b1;
                    w_clr            = 1'b1;
                    w_count_nxt      = c_CNT_ZERO;
                    w_state_nxt      = S_IDLE;
                end
            end
            S_COMMIT: begin
                w_commit    = 1'b1;
                w_clr       = 1'b1;
                w_count_nxt = c_CNT_ZERO;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_clr       = 1'b1;
                w_count_nxt = c_CNT_ZERO;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            r_state      <= S_IDLE;
            r_count      <= c_CNT_ZERO;
            r_shadow     <= '0;
            r_mem        <= '0;
            r_mem_inv    <= '1;
            r_load_done  <= 1'b0;
            r_err_len    <= 1'b0;
            r_err_onehot <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_count      <= w_count_nxt;
            r_load_done  <= w_commit;
            r_err_len    <= w_err_len_set;
            r_err_onehot <= w_err_onehot_set;
            if (w_clr) begin
                r_shadow <= '0;
            end else if (w_wr_en) begin
                for (int k = 0; k < c_NWORDS; k++) begin
                    if (w_wr_idx == c_CNT_W'(k)) begin
                        for (int j = 0; j < WORD_W; j++) begin
                            r_shadow[k*WORD_W + j] <= in_data[j];
                        end
                    end
                end
            end
            // mem and mem_inv move together, whole frame at once.
            if (w_commit) begin
                r_mem     <= r_shadow;
                r_mem_inv <= ~r_shadow;
            end
        end
    end

    assign mem        = r_mem;
    assign mem_inv    = r_mem_inv;
    assign load_done  = r_load_done;
    assign err_len    = r_err_len;
    assign err_onehot = r_err_onehot;
    assign cfg_busy   = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mux_cfg_frame_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mux_cfg_frame_loader
// Description : Self-checking bench for mux_cfg_frame_loader with MEM_SIZE=8,
//               WORD_W=4 and ONEHOT_GROUP=4. Each frame's expected outcome is
//               queued when it is driven. A monitor pops the queue whenever
//               the loader pulses load_done, err_len or err_onehot.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_cfg_frame_loader;

    localparam logic [2:0] K_DONE = 3'b100;
    localparam logic [2:0] K_LEN  = 3'b010;
    localparam logic [2:0] K_OH   = 3'b001;

    typedef struct {
        logic [2:0] kind;
        logic [0:7] bits;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_data = 4'h0;
    logic       in_last = 1'b0;
    logic [0:7] mem;
    logic [0:7] mem_inv;
    logic       load_done;
    logic       err_len;
    logic       err_onehot;
    logic       cfg_busy;

    int         n_checks = 0;
    int         n_fail   = 0;
    exp_t       exp_q[$];
    exp_t       e_mon;
    logic [0:7] last_mem = 8'h00;

    mux_cfg_frame_loader #(
        .MEM_SIZE    (8),
        .WORD_W      (4),
        .ONEHOT_GROUP(4)
    ) u_dut (
        .prog_clk  (clk),
        .pReset    (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .mem       (mem),
        .mem_inv   (mem_inv),
        .load_done (load_done),
        .err_len   (err_len),
        .err_onehot(err_onehot),
        .cfg_busy  (cfg_busy)
    );

    always #5 clk = ~clk;

    // Expected select image: bit j of word k lands at mem[k*4+j].
    function automatic logic [0:7] frame_bits(input logic [3:0] w0, input logic [3:0] w1);
        logic [0:7] b;
        for (int j = 0; j < 4; j++) begin
            b[j]     = w0[j];
            b[4 + j] = w1[j];
        end
        return b;
    endfunction

    // Scoreboard: every result pulse must match the oldest queued outcome.
    always @(negedge clk) begin
        if (!rst && (load_done || err_len || err_onehot)) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: pulses done/len/oh=%b%b%b, none expected", load_done, err_len, err_onehot);
            end else begin
                e_mon = exp_q.pop_front();
                if ({load_done, err_len, err_onehot} !== e_mon.kind ||
                    (e_mon.kind == K_DONE && (mem !== e_mon.bits || mem_inv !== ~e_mon.bits))) begin
                    n_fail++;
                    $display("FAIL sb_result: got pulses %b mem %b inv %b, want pulses %b mem %b",
                             {load_done, err_len, err_onehot}, mem, mem_inv, e_mon.kind, e_mon.bits);
                end
            end
        end
    end

    // Offers one word, holds it until accepted, returns negedges spent waiting
    // for in_ready. Leaves the task 1 ns after the accepting edge.
    task automatic send_word(input logic [3:0] d, input logic last, output int waited);
        waited   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (in_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles, want 1", in_ready, waited);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 4'($urandom);
        in_last  = 1'($urandom);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            in_data = 4'($urandom);
            in_last = 1'($urandom);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_cycles(3);
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_low: got %b want 0", in_ready); end
        n_checks++;
        if (mem !== 8'h00 || mem_inv !== 8'hFF) begin n_fail++; $display("FAIL reset_mem: got %h/%h want 00/ff", mem, mem_inv); end
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_release: got %b want 1", in_ready); end
        n_checks++;
        if ({load_done, err_len, err_onehot, cfg_busy} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0000", {load_done, err_len, err_onehot, cfg_busy});
        end
    endtask

    task automatic test_good_frame();
        int w;
        exp_q.push_back('{kind: K_DONE, bits: 8'b0100_0001});
        send_word(4'b0010, 1'b0, w);
        send_word(4'b1000, 1'b1, w);
        n_checks++;
        if (in_ready !== 1'b0 || load_done !== 1'b0 || mem !== last_mem) begin
            n_fail++; $display("FAIL good_t1: ready %b done %b mem %b, want 0 0 %b", in_ready, load_done, mem, last_mem);
        end
        idle_cycles(1);
        n_checks++;
        if (in_ready !== 1'b0 || load_done !== 1'b0 || mem !== last_mem) begin
            n_fail++; $display("FAIL good_t2: ready %b done %b mem %b, want 0 0 %b", in_ready, load_done, mem, last_mem);
        end
        idle_cycles(1);
        n_checks++;
        if (load_done !== 1'b1 || in_ready !== 1'b1 || mem !== 8'b0100_0001 || mem_inv !== 8'b1011_1110) begin
            n_fail++; $display("FAIL good_commit: done %b ready %b mem %b inv %b, want 1 1 01000001 10111110",
                               load_done, in_ready, mem, mem_inv);
        end
        last_mem = 8'b0100_0001;
        idle_cycles(1);
        n_checks++;
        if (load_done !== 1'b0) begin n_fail++; $display("FAIL good_pulse_width: done %b want 0", load_done); end
    endtask

    task automatic test_onehot_err();
        int w;
        exp_q.push_back('{kind: K_OH, bits: 8'h00});
        send_word(4'b0011, 1'b0, w);
        send_word(4'b0001, 1'b1, w);
        n_checks++;
        if (err_onehot !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL oh_t1: err %b ready %b, want 0 0", err_onehot, in_ready);
        end
        idle_cycles(1);
        n_checks++;
        if (err_onehot !== 1'b1 || load_done !== 1'b0 || in_ready !== 1'b1 || mem !== last_mem || mem_inv !== ~last_mem) begin
            n_fail++; $display("FAIL oh_result: err %b done %b ready %b mem %b, want 1 0 1 %b",
                               err_onehot, load_done, in_ready, mem, last_mem);
        end
        idle_cycles(2);
    endtask

    task automatic test_len_err();
        int w;
        exp_q.push_back('{kind: K_LEN, bits: 8'h00});
        send_word(4'b0001, 1'b1, w);
        n_checks++;
        if (err_len !== 1'b1 || cfg_busy !== 1'b0) begin
            n_fail++; $display("FAIL len_short: err %b busy %b, want 1 0", err_len, cfg_busy);
        end
        send_word(4'b0001, 1'b0, w);
        exp_q.push_back('{kind: K_LEN, bits: 8'h00});
        send_word(4'b0010, 1'b0, w);
        n_checks++;
        if (err_len !== 1'b1 || cfg_busy !== 1'b1) begin
            n_fail++; $display("FAIL len_long: err %b busy %b, want 1 1", err_len, cfg_busy);
        end
        send_word(4'b0100, 1'b1, w);
        n_checks++;
        if (err_len !== 1'b0 || cfg_busy !== 1'b0 || mem !== last_mem) begin
            n_fail++; $display("FAIL len_drain: err %b busy %b mem %b, want 0 0 %b", err_len, cfg_busy, mem, last_mem);
        end
        exp_q.push_back('{kind: K_DONE, bits: 8'b0001_0010});
        send_word(4'b1000, 1'b0, w);
        send_word(4'b0100, 1'b1, w);
        idle_cycles(2);
        n_checks++;
        if (load_done !== 1'b1 || mem !== 8'b0001_0010) begin
            n_fail++; $display("FAIL len_recover: done %b mem %b, want 1 00010010", load_done, mem);
        end
        last_mem = 8'b0001_0010;
    endtask

    task automatic test_gaps();
        int w;
        exp_q.push_back('{kind: K_DONE, bits: 8'b0010_1000});
        send_word(4'b0100, 1'b0, w);
        send_word(4'b0001, 1'b1, w);
        idle_cycles(3);
        n_checks++;
        if (mem !== 8'b0010_1000) begin n_fail++; $display("FAIL gap_pre: mem %b want 00101000", mem); end
        exp_q.push_back('{kind: K_DONE, bits: 8'b0100_0001});
        send_word(4'b0010, 1'b0, w);
        idle_cycles(3);
        send_word(4'b1000, 1'b1, w);
        idle_cycles(3);
        n_checks++;
        if (mem !== 8'b0100_0001 || mem_inv !== 8'b1011_1110) begin
            n_fail++; $display("FAIL gap_mem: mem %b inv %b want 01000001 10111110", mem, mem_inv);
        end
        last_mem = 8'b0100_0001;
    endtask

    // in_valid stays high from frame to frame; the first word of each frame
    // waits 3 negedges after a committed frame (CHECK, COMMIT) and 2 after a
    // rejected one (CHECK only).
    task automatic test_back_to_back();
        int         w;
        int         want_wait;
        logic [3:0] wd[2];
        logic [0:7] b;
        bit         ok;
        want_wait = 0;
        for (int f = 0; f < 10; f++) begin
            for (int k = 0; k < 2; k++) begin
                int r = $urandom_range(0, 6);
                if (r == 0)      wd[k] = 4'b0000;
                else if (r <= 4) wd[k] = 4'(1 << (r - 1));
                else if (r == 5) wd[k] = 4'b0110;
                else             wd[k] = 4'b1001;
            end
            b  = frame_bits(wd[0], wd[1]);
            ok = ($countones(wd[0]) <= 1) && ($countones(wd[1]) <= 1);
            exp_q.push_back('{kind: ok ? K_DONE : K_OH, bits: b});
            send_word(wd[0], 1'b0, w);
            if (f > 0) begin
                n_checks++;
                if (w != want_wait) begin
                    n_fail++; $display("FAIL b2b_ready_gap frame %0d: waited %0d want %0d", f, w, want_wait);
                end
            end
            send_word(wd[1], 1'b1, w);
            in_valid = 1'b1;
            if (ok) last_mem = b;
            want_wait = ok ? 3 : 2;
        end
        in_valid = 1'b0;
        idle_cycles(4);
        n_checks++;
        if (mem !== last_mem || mem_inv !== ~last_mem) begin
            n_fail++; $display("FAIL b2b_final_mem: mem %b inv %b want %b", mem, mem_inv, last_mem);
        end
    endtask

    task automatic test_reset_midframe();
        int w;
        send_word(4'b0010, 1'b0, w);
        rst = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready: got %b want 0", in_ready); end
        idle_cycles(1);
        rst = 1'b0;
        #1;
        n_checks++;
        if (mem !== 8'h00 || mem_inv !== 8'hFF || cfg_busy !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL midrst_state: mem %h inv %h busy %b ready %b, want 00 ff 0 1", mem, mem_inv, cfg_busy, in_ready);
        end
        last_mem = 8'h00;
        exp_q.push_back('{kind: K_DONE, bits: 8'b1000_0010});
        send_word(4'b0001, 1'b0, w);
        send_word(4'b0100, 1'b1, w);
        idle_cycles(2);
        n_checks++;
        if (load_done !== 1'b1 || mem !== 8'b1000_0010) begin
            n_fail++; $display("FAIL midrst_reload: done %b mem %b want 1 10000010", load_done, mem);
        end
        last_mem = 8'b1000_0010;
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_onehot_err();
        test_len_err();
        test_gaps();
        test_back_to_back();
        test_reset_midframe();
        idle_cycles(4);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL sb_leftover: %0d expected outcomes never seen, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, want finish before 200 us");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
